// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a 2-flop synchroniser, mid-bit sampling and a valid/ready holding register.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1 selected by PARITY_ODD); default build is 8N1.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       par_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 8 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx: CLKS_PER_BIT must be >= 8 and PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    state_t             state;
    logic               sync1;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         idx;
    logic [7:0]         shift;
    logic               deliver;

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            deliver   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            deliver   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
            // The completed byte waits in shift for one cycle; a new frame cannot reach bit 0 that fast.
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end

            cnt <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        par_err <= ((^shift) ^ rx_s) != (PARITY_ODD != 0);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            deliver <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
